pipelined_addsub: RTL
=====================

# pipelined_addsub

Parametrised, pipelined two's-complement adder/subtractor that splits a WIDTH-bit operation into SEG-bit segments, one segment per pipeline stage, with the inter-segment carry registered between stages. It succeeds the fixed 16-bit ripple adder chain in the arithmetic circuits. It is the ALU's multi-cycle add path, fed from operand latches through a valid/ready handshake. It sustains one operation per cycle with backpressure, a subtract mode, status flags and a synchronous flush.

## Interface
- WIDTH, 32, operand/result width; must be a multiple of SEG.
- SEG, 8, bits added per stage; STAGES = WIDTH/SEG (1..WIDTH).
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operands/mode valid.
- in_ready  out  1  block can accept this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- carry_in  in  1  carry into bit 0 (add mode only).
- sub  in  1  0 = A+B+carry_in, 1 = A−B (A + ~B + 1; carry_in ignored).
- flush  in  1  synchronous pipeline clear.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- sum  out  WIDTH  result, modulo 2^WIDTH.
- carry_out  out  1  carry out of bit WIDTH−1 (sub: 1 = no borrow).
- overflow  out  1  signed overflow: carry into MSB XOR carry_out.
- zero  out  1  sum == 0.

## Operation
- One clock; reset is asynchronous and active-low.
- Stage k (1..STAGES) register holds: valid bit, remaining operand segments, sum segments 0..k−1, and the carry out of segment k−1.
- Acceptance: at the accepting edge, stage 1 loads segment 0 of A + B' + c0, where B' = sub ? ~b : b and c0 = sub ? 1 : carry_in. It also loads the remaining segments of A and B'.
- Stage k+1 adds segment k of A and B' plus the registered carry from stage k.
- The final stage drives sum, carry_out, overflow and zero directly from registers. Flags are computed when the last segment is added, not combinationally at the output.
- Global enable: en = !(out_valid && !out_ready). While en = 0, all stages hold their contents.
- in_ready = en && !flush. Accept = in_valid && in_ready.
- Bubbles: when no input is accepted while en = 1, a stage-1 valid of 0 enters. Bubbles are not compressed.
- flush: at the next edge all stage valid bits clear (out_valid → 0). Data registers may hold stale values. No input is accepted during a flush cycle. flush overrides stall.
- Reset mid-operation discards all in-flight results. No partial result is ever presented.

## Timing
- Reset values: out_valid 0, sum 0, carry_out 0, overflow 0, zero 0, all stage valids 0. in_ready = 1 once rst_n is high and flush = 0.
- Latency:
  - An operation accepted at edge t0 appears with out_valid = 1 after edge t0+STAGES−1, provided there are no stalls.
  - STAGES = 1 gives the result the cycle after acceptance.
- Throughput: one op per cycle when out_ready is held at 1.
- Output transfer happens on an edge where out_valid && out_ready.
- sum and flags stay stable while out_valid && !out_ready.
- Backpressure is combinational: in_ready depends combinationally on out_ready in the same cycle.
- Simultaneous output transfer and input acceptance in one cycle is legal; the pipeline advances.
- Results leave in acceptance order. No reordering.

## Test plan
- Reset/idle: assert rst_n = 0 mid-stream for 2 cycles, then release.
  - Required: all outputs 0, out_valid 0, in_ready 1, and no stale result emerges later.
- Carry ripple (WIDTH 32, SEG 8): a = 0xFFFFFFFF, b = 0x00000001, add, cin 0, accepted at t0.
  - Required: out_valid after edge t0+3, sum 0, carry_out 1, zero 1, overflow 0.
- Signed overflow and subtract: two back-to-back operations.
  - a = 0x7FFFFFFF, b = 1, add → sum 0x80000000, overflow 1, carry_out 0.
  - Next cycle: sub, a = 5, b = 7 → sum 0xFFFFFFFE, carry_out 0, overflow 0.
  - Results appear on consecutive cycles.
- Backpressure: stream 10 random ops with out_ready toggling pseudo-randomly.
  - Required: every result matches a reference model in order, with no drops or duplicates.
  - sum is stable whenever out_valid && !out_ready.
- Flush: accept 3 ops, assert flush for 1 cycle with in_valid high.
  - Required: in_ready 0 that cycle, out_valid 0 next cycle, and none of the 3 results ever appear.
  - The next accepted op completes normally.
- Parameter sweep: (WIDTH, SEG) = (16,16), (16,4), (32,1), run with 1000 random ops.
  - Required: latency equals WIDTH/SEG and all results match.

Source files
------------

// File: rtl/pipelined_addsub.sv
// Segmented, pipelined two's-complement adder/subtractor.
// Each stage adds one SEG-bit slice and registers the slice carry for the next
// stage. The last stage owns the visible result and the status flags, so
// sum/carry_out/overflow/zero come straight from flops.
module pipelined_addsub #(
  parameter int WIDTH = 32,
  parameter int SEG   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
  input  logic             sub,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow,
  output logic             zero
);

  localparam int STAGES = WIDTH / SEG;

  // Stage registers: operands travel along so each stage finds its own slice;
  // b is stored already inverted for subtract.
  logic [STAGES-1:0] vld_q, vld_d;
  logic [STAGES-1:0] c_q, c_d;
  logic [WIDTH-1:0]  a_q [STAGES];
  logic [WIDTH-1:0]  a_d [STAGES];
  logic [WIDTH-1:0]  b_q [STAGES];
  logic [WIDTH-1:0]  b_d [STAGES];
  logic [WIDTH-1:0]  s_q [STAGES];
  logic [WIDTH-1:0]  s_d [STAGES];
  logic              ovf_q, ovf_d;
  logic              zero_q, zero_d;

  // Inputs seen by each stage this cycle (front-end operands or previous stage).
  logic [STAGES-1:0] src_v, src_c;
  logic [WIDTH-1:0]  src_a [STAGES];
  logic [WIDTH-1:0]  src_b [STAGES];
  logic [WIDTH-1:0]  src_s [STAGES];
  logic [SEG:0]      seg_sum [STAGES];

  logic en;
  logic accept;

  // A stalled output freezes the whole pipe; flush blocks new operands.
  assign out_valid = vld_q[STAGES-1];
  assign en        = !(out_valid && !out_ready);
  assign in_ready  = en && !flush;
  assign accept    = in_valid && in_ready;

  assign sum       = s_q[STAGES-1];
  assign carry_out = c_q[STAGES-1];
  assign overflow  = ovf_q;
  assign zero      = zero_q;

  // Per-stage slice addition and next-state assembly.
  always_comb begin
    src_v = '0;
    src_c = '0;
    vld_d = '0;
    c_d   = '0;
    for (int i = 0; i < STAGES; i++) begin
      src_a[i]   = '0;
      src_b[i]   = '0;
      src_s[i]   = '0;
      seg_sum[i] = '0;
      a_d[i]     = '0;
      b_d[i]     = '0;
      s_d[i]     = '0;
    end

    src_v[0] = accept;
    src_a[0] = a;
    src_b[0] = sub ? ~b : b;
    src_c[0] = sub ? 1'b1 : carry_in;
    src_s[0] = '0;
    for (int i = 1; i < STAGES; i++) begin
      src_v[i] = vld_q[i-1];
      src_a[i] = a_q[i-1];
      src_b[i] = b_q[i-1];
      src_c[i] = c_q[i-1];
      src_s[i] = s_q[i-1];
    end

    for (int i = 0; i < STAGES; i++) begin
      seg_sum[i] = {1'b0, src_a[i][i*SEG +: SEG]}
                 + {1'b0, src_b[i][i*SEG +: SEG]}
                 + {{SEG{1'b0}}, src_c[i]};
      s_d[i]                = src_s[i];
      s_d[i][i*SEG +: SEG]  = seg_sum[i][SEG-1:0];
      c_d[i]                = seg_sum[i][SEG];
      a_d[i]                = src_a[i];
      b_d[i]                = src_b[i];
      vld_d[i]              = src_v[i];
    end

    // Signed overflow: both addends share a sign the result does not.
    ovf_d  = (src_a[STAGES-1][WIDTH-1] == src_b[STAGES-1][WIDTH-1]) &&
             (s_d[STAGES-1][WIDTH-1] != src_a[STAGES-1][WIDTH-1]);
    zero_d = (s_d[STAGES-1] == '0);
  end

  // Pipeline registers: flush drops valids only, stall holds everything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q  <= '0;
      c_q    <= '0;
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
      for (int i = 0; i < STAGES; i++) begin
        a_q[i] <= '0;
        b_q[i] <= '0;
        s_q[i] <= '0;
      end
    end else if (flush) begin
      vld_q <= '0;
    end else if (en) begin
      vld_q  <= vld_d;
      c_q    <= c_d;
      ovf_q  <= ovf_d;
      zero_q <= zero_d;
      for (int i = 0; i < STAGES; i++) begin
        a_q[i] <= a_d[i];
        b_q[i] <= b_d[i];
        s_q[i] <= s_d[i];
      end
    end
  end

endmodule
